// File: rtl/video_timing_pkg.sv
// Shared types and default 640x480@60 raster constants for the video timing generator.
package video_timing_pkg;

   localparam int COORD_W      = 12;
   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   typedef struct packed {
      logic               de;
      logic               hsync;
      logic               vsync;
      logic               line_start;
      logic               frame_start;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } timing_t;

   function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   // Blanking payload: no data, no pulses, syncs at their deasserted level.
   function automatic timing_t timing_idle(input logic hs_on, input logic vs_on);
      timing_t t;
      t       = '0;
      t.hsync = ~hs_on;
      t.vsync = ~vs_on;
      return t;
   endfunction

endpackage

// File: rtl/video_timing_generator_delay.sv
// Fixed-depth shift register of timing_t; reset loads the blanking payload into every stage.
module timing_delay_line
   import video_timing_pkg::*;
#(
   parameter int      DEPTH = 2,
   parameter timing_t IDLE  = '0
) (
   input  logic    clk,
   input  logic    rst,
   input  timing_t din,
   output timing_t dout
);

   timing_t stage [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= IDLE;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/video_timing_generator.sv
// Raster timing source: lead counters, registered pixel request, and a delayed display-side copy.
module video_timing_generator
   import video_timing_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF,
   parameter int H_POL    = 0,
   parameter int V_POL    = 0,
   parameter int PREFETCH = 2,
   parameter int CW       = COORD_W
) (
   input  logic          clk,
   input  logic          rst,
   output logic          de,
   output logic          hsync,
   output logic          vsync,
   output logic [1:0]    ctrl0,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          line_start,
   output logic          frame_start,
   output logic          pix_req,
   output logic [CW-1:0] req_x,
   output logic [CW-1:0] req_y
);

   localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT_N  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT_N  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEGIN = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_BEGIN = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic          HS_ON    = (H_POL != 0);
   localparam logic          VS_ON    = (V_POL != 0);
   localparam timing_t       IDLE     = timing_idle(HS_ON, VS_ON);

   logic [CW-1:0] h;
   logic [CW-1:0] v;
   logic          h_wrap;
   logic          active;
   timing_t       lead_d;
   timing_t       lead_q;
   timing_t       out_q;

   assign h_wrap = (h == H_LAST);

   // v steps only on the h wrap, so the last cycle of a frame wraps both together.
   always_ff @(posedge clk) begin
      if (rst) begin
         h <= '0;
         v <= '0;
      end else begin
         h <= h_wrap ? '0 : h + CW'(1);
         if (h_wrap) v <= (v == V_LAST) ? '0 : v + CW'(1);
      end
   end

   always_comb begin
      active             = (h < H_ACT_N) && (v < V_ACT_N);
      lead_d             = IDLE;
      lead_d.de          = active;
      lead_d.hsync       = ((h >= HS_BEGIN) && (h < HS_END)) ? HS_ON : ~HS_ON;
      lead_d.vsync       = ((v >= VS_BEGIN) && (v < VS_END)) ? VS_ON : ~VS_ON;
      lead_d.line_start  = active && (h == '0);
      lead_d.frame_start = active && (h == '0) && (v == '0);
      lead_d.x           = active ? COORD_W'(h) : '0;
      lead_d.y           = active ? COORD_W'(v) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pix_req <= 1'b0;
         req_x   <= '0;
         req_y   <= '0;
         lead_q  <= IDLE;
      end else begin
         pix_req <= active;
         req_x   <= active ? h : '0;
         req_y   <= active ? v : '0;
         lead_q  <= lead_d;
      end
   end

   // PREFETCH more stages so de lands exactly PREFETCH cycles after its pix_req.
   timing_delay_line #(
      .DEPTH (PREFETCH),
      .IDLE  (IDLE)
   ) u_delay (
      .clk  (clk),
      .rst  (rst),
      .din  (lead_q),
      .dout (out_q)
   );

   assign de          = out_q.de;
   assign hsync       = out_q.hsync;
   assign vsync       = out_q.vsync;
   assign line_start  = out_q.line_start;
   assign frame_start = out_q.frame_start;
   assign x           = CW'(out_q.x);
   assign y           = CW'(out_q.y);
   assign ctrl0       = {out_q.vsync, out_q.hsync};

endmodule

// File: tb/tb_video_timing_generator.sv
// Bench: three raster configurations checked against a position-arithmetic reference model.
module tb_video_timing_generator;

   typedef struct { int ha, hf, hs, hb, va, vf, vs, vb, hpol, vpol, pf; } cfg_t;
   typedef struct { int pr, rx, ry, de, hs, vs, c0, x, y, ls, fs; } obs_t;
   typedef struct { logic rst; int pr, rx, de, fs, x, y, hs, vs; } vec_t;
   typedef struct { int due, x, y; } req_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
   int   checks = 0, errors = 0;
   logic chk_en = 1'b0;
   int   ka = 0, kb = 0, kc = 0;

   cfg_t cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2};
   cfg_t cfg_b = '{8, 1, 2, 1, 4, 1, 1, 1, 0, 0, 3};
   cfg_t cfg_c = '{20, 3, 5, 4, 10, 2, 3, 2, 1, 1, 1};

   logic de_a, hsync_a, vsync_a, ls_a, fs_a, pr_a;
   logic de_b, hsync_b, vsync_b, ls_b, fs_b, pr_b;
   logic de_c, hsync_c, vsync_c, ls_c, fs_c, pr_c;
   logic [1:0]  c0_a, c0_b, c0_c;
   logic [11:0] x_a, y_a, rx_a, ry_a, x_b, y_b, rx_b, ry_b, x_c, y_c, rx_c, ry_c;

   video_timing_generator dut_a (
      .clk(clk), .rst(rst_a), .de(de_a), .hsync(hsync_a), .vsync(vsync_a), .ctrl0(c0_a),
      .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a),
      .pix_req(pr_a), .req_x(rx_a), .req_y(ry_a));

   video_timing_generator #(
      .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_POL(0), .V_POL(0), .PREFETCH(3), .CW(12)
   ) dut_b (
      .clk(clk), .rst(rst_b), .de(de_b), .hsync(hsync_b), .vsync(vsync_b), .ctrl0(c0_b),
      .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b),
      .pix_req(pr_b), .req_x(rx_b), .req_y(ry_b));

   video_timing_generator #(
      .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
      .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2),
      .H_POL(1), .V_POL(1), .PREFETCH(1), .CW(12)
   ) dut_c (
      .clk(clk), .rst(rst_c), .de(de_c), .hsync(hsync_c), .vsync(vsync_c), .ctrl0(c0_c),
      .x(x_c), .y(y_c), .line_start(ls_c), .frame_start(fs_c),
      .pix_req(pr_c), .req_x(rx_c), .req_y(ry_c));

   // k = clock edges since reset was last sampled high.
   always @(posedge clk) begin
      ka <= rst_a ? 0 : ka + 1;
      kb <= rst_b ? 0 : kb + 1;
      kc <= rst_c ? 0 : kc + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected outputs after k edges: request side shows raster position k-1, display side k-1-PREFETCH.
   function automatic obs_t model(input cfg_t c, input int k);
      obs_t o;
      int ht, vt, p, h, v;
      ht = c.ha + c.hf + c.hs + c.hb;
      vt = c.va + c.vf + c.vs + c.vb;
      o = '{default: 0};
      o.hs = (c.hpol == 0) ? 1 : 0;
      o.vs = (c.vpol == 0) ? 1 : 0;
      if (k >= 1) begin
         p = (k - 1) % (ht * vt);
         h = p % ht;
         v = p / ht;
         if (h < c.ha && v < c.va) begin
            o.pr = 1; o.rx = h; o.ry = v;
         end
      end
      if (k >= 1 + c.pf) begin
         p = (k - 1 - c.pf) % (ht * vt);
         h = p % ht;
         v = p / ht;
         if (h < c.ha && v < c.va) begin
            o.de = 1; o.x = h; o.y = v;
            o.ls = (h == 0) ? 1 : 0;
            o.fs = (h == 0 && v == 0) ? 1 : 0;
         end
         if (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) o.hs = c.hpol;
         if (v >= c.va + c.vf && v < c.va + c.vf + c.vs) o.vs = c.vpol;
      end
      o.c0 = o.vs * 2 + o.hs;
      return o;
   endfunction

   task automatic cmp_obs(input string tag, input obs_t a, input obs_t e);
      chk({tag, ".pix_req"}, a.pr, e.pr);
      chk({tag, ".req_x"}, a.rx, e.rx);
      chk({tag, ".req_y"}, a.ry, e.ry);
      chk({tag, ".de"}, a.de, e.de);
      chk({tag, ".hsync"}, a.hs, e.hs);
      chk({tag, ".vsync"}, a.vs, e.vs);
      chk({tag, ".ctrl0"}, a.c0, e.c0);
      chk({tag, ".x"}, a.x, e.x);
      chk({tag, ".y"}, a.y, e.y);
      chk({tag, ".line_start"}, a.ls, e.ls);
      chk({tag, ".frame_start"}, a.fs, e.fs);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp_obs("A", '{int'(pr_a), int'(rx_a), int'(ry_a), int'(de_a), int'(hsync_a), int'(vsync_a),
                        int'(c0_a), int'(x_a), int'(y_a), int'(ls_a), int'(fs_a)}, model(cfg_a, ka));
         cmp_obs("B", '{int'(pr_b), int'(rx_b), int'(ry_b), int'(de_b), int'(hsync_b), int'(vsync_b),
                        int'(c0_b), int'(x_b), int'(y_b), int'(ls_b), int'(fs_b)}, model(cfg_b, kb));
         cmp_obs("C", '{int'(pr_c), int'(rx_c), int'(ry_c), int'(de_c), int'(hsync_c), int'(vsync_c),
                        int'(c0_c), int'(x_c), int'(y_c), int'(ls_c), int'(fs_c)}, model(cfg_c, kc));
      end
   end

   // Request scoreboard for B: each pix_req must reappear as de with the same coordinates 3 cycles on.
   req_t sb_q[$];
   always @(negedge clk) begin
      req_t e;
      if (chk_en) begin
         if (kb == 0) sb_q.delete();
         if (sb_q.size() > 0 && sb_q[0].due == kb) begin
            e = sb_q.pop_front();
            chk("B.sb_de", int'(de_b), 1);
            chk("B.sb_x", int'(x_b), e.x);
            chk("B.sb_y", int'(y_b), e.y);
         end else begin
            chk("B.sb_unrequested_de", int'(de_b), 0);
         end
         if (pr_b) sb_q.push_back('{kb + 3, int'(rx_b), int'(ry_b)});
      end
   end

   task automatic run_a();
      vec_t vt[8];
      int de_rise = -1, de_fall = -1, hs_fall = -1, hs_rise = -1, ls_prev = -1, ls_int = -1;
      int t_pr = -1, t_fs = -1, stray = 0;
      logic de_p = 1'b1, hs_p = 1'b1, found = 1'b0;
      vt[0] = '{1'b1, 0, 0, 0, 0, 0, 0, 1, 1};
      vt[1] = '{1'b1, 0, 0, 0, 0, 0, 0, 1, 1};
      vt[2] = '{1'b1, 0, 0, 0, 0, 0, 0, 1, 1};
      vt[3] = '{1'b0, 1, 0, 0, 0, 0, 0, 1, 1};
      vt[4] = '{1'b0, 1, 1, 0, 0, 0, 0, 1, 1};
      vt[5] = '{1'b0, 1, 2, 1, 1, 0, 0, 1, 1};
      vt[6] = '{1'b0, 1, 3, 1, 0, 1, 0, 1, 1};
      vt[7] = '{1'b0, 1, 4, 1, 0, 2, 0, 1, 1};
      for (int i = 0; i < 8; i++) begin
         rst_a = vt[i].rst;
         @(posedge clk);
         #1;
         chk($sformatf("A.vec%0d.pix_req", i), int'(pr_a), vt[i].pr);
         chk($sformatf("A.vec%0d.req_x", i), int'(rx_a), vt[i].rx);
         chk($sformatf("A.vec%0d.de", i), int'(de_a), vt[i].de);
         chk($sformatf("A.vec%0d.frame_start", i), int'(fs_a), vt[i].fs);
         chk($sformatf("A.vec%0d.x", i), int'(x_a), vt[i].x);
         chk($sformatf("A.vec%0d.y", i), int'(y_a), vt[i].y);
         chk($sformatf("A.vec%0d.hsync", i), int'(hsync_a), vt[i].hs);
         chk($sformatf("A.vec%0d.vsync", i), int'(vsync_a), vt[i].vs);
      end
      for (int i = 0; i < 2400; i++) begin
         @(negedge clk);
         if (de_a && !de_p && de_rise < 0) de_rise = ka;
         if (!de_a && de_p && de_rise >= 0 && de_fall < 0) de_fall = ka;
         if (!hsync_a && hs_p && de_fall >= 0 && hs_fall < 0) hs_fall = ka;
         if (hsync_a && !hs_p && hs_fall >= 0 && hs_rise < 0) hs_rise = ka;
         if (ls_a) begin
            if (ls_prev >= 0 && ls_int < 0) ls_int = ka - ls_prev;
            ls_prev = ka;
         end
         de_p = de_a;
         hs_p = hsync_a;
      end
      chk("A.de_run_len", de_fall - de_rise, 640);
      chk("A.hsync_after_de", hs_fall - de_fall, 16);
      chk("A.hsync_width", hs_rise - hs_fall, 96);
      chk("A.line_period", ls_int, 800);
      for (int i = 0; i < 3000 && !found; i++) begin
         @(negedge clk);
         if (de_a && x_a == 12'd100 && y_a == 12'd3) found = 1'b1;
      end
      chk("A.reached_100_3", int'(found), 1);
      rst_a = 1'b1;
      @(posedge clk);
      #1;
      chk("A.midrst.de", int'(de_a), 0);
      chk("A.midrst.pix_req", int'(pr_a), 0);
      chk("A.midrst.hsync", int'(hsync_a), 1);
      chk("A.midrst.x", int'(x_a), 0);
      chk("A.midrst.pulses", int'(ls_a) + int'(fs_a), 0);
      @(negedge clk);
      rst_a = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk);
         #1;
         if (pr_a && rx_a == 12'd0 && ry_a == 12'd0 && t_pr < 0) t_pr = i;
         if (fs_a && t_fs < 0) t_fs = i;
         if (i < 3 && (ls_a || fs_a || de_a)) stray++;
      end
      chk("A.restart_req_latency", t_pr, 1);
      chk("A.restart_frame_latency", t_fs, 3);
      chk("A.restart_stray", stray, 0);
   endtask

   task automatic run_b();
      int t_fs_prev = -1, fs_int = -1, t_last = -1, gap = -1;
      @(negedge clk);
      @(negedge clk);
      rst_b = 1'b0;
      for (int i = 0; i < 250; i++) begin
         @(negedge clk);
         if (fs_b) begin
            if (t_fs_prev >= 0 && fs_int < 0) fs_int = kb - t_fs_prev;
            t_fs_prev = kb;
         end
         if (pr_b && rx_b == 12'd7 && ry_b == 12'd3) t_last = kb;
         if (pr_b && rx_b == 12'd0 && ry_b == 12'd0 && t_last >= 0 && gap < 0) gap = kb - t_last;
      end
      chk("B.frame_period", fs_int, 84);
      chk("B.last_to_first_req", gap, 41);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 149) == 0) begin
            rst_b = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst_b = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   task automatic run_c();
      int t9 = -1, tv = -1, tve = -1, ths = -1, the = -1, t_fs_prev = -1, fs_int = -1, bad = 0;
      logic vs_p = 1'b0, hs_p = 1'b0;
      @(negedge clk);
      rst_c = 1'b0;
      for (int i = 0; i < 1300; i++) begin
         @(negedge clk);
         if (ls_c && y_c == 12'd9 && t9 < 0) t9 = kc;
         if (vsync_c && !vs_p && t9 >= 0 && tv < 0) tv = kc;
         if (!vsync_c && vs_p && tv >= 0 && tve < 0) tve = kc;
         if (hsync_c && !hs_p && ths < 0) ths = kc;
         if (!hsync_c && hs_p && ths >= 0 && the < 0) the = kc;
         if (fs_c) begin
            if (t_fs_prev >= 0 && fs_int < 0) fs_int = kc - t_fs_prev;
            t_fs_prev = kc;
         end
         if (de_c && y_c >= 12'd10) bad++;
         vs_p = vsync_c;
         hs_p = hsync_c;
      end
      chk("C.vsync_after_last_line", tv - t9, 96);
      chk("C.vsync_width", tve - tv, 96);
      chk("C.hsync_width", the - ths, 5);
      chk("C.frame_period", fs_int, 544);
      chk("C.de_in_vblank", bad, 0);
   endtask

   initial begin
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      fork
         run_a();
         run_b();
         run_c();
      join
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
